// File: rtl/tag_free_list.sv
// Circular free list of physical rename tags: up to NUM_ISSUE all-or-nothing grants per cycle,
// up to NUM_COMMIT prev-tag frees per cycle, and spec-to-committed rollback on mispredict.
module tag_free_list #(
  parameter int NUM_ISSUE  = 4,
  parameter int NUM_COMMIT = 4,
  parameter int TAG_SIZE   = 7
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 IN_mispred,
  input  logic                                 IN_mispredFlush,
  input  logic [NUM_ISSUE-1:0]                 IN_allocReq,
  input  logic                                 IN_allocFire,
  output logic [NUM_ISSUE-1:0][TAG_SIZE-1:0]   OUT_allocTags,
  output logic                                 OUT_allocOK,
  input  logic [NUM_COMMIT-1:0]                IN_commitValid,
  input  logic [NUM_COMMIT-1:0][TAG_SIZE-1:0]  IN_commitTags,
  input  logic [NUM_COMMIT-1:0][TAG_SIZE-1:0]  IN_commitPrevTags,
  output logic [TAG_SIZE-1:0]                  OUT_freeCount
);
  localparam int IW       = TAG_SIZE - 1;
  localparam int NUM_TAGS = 1 << IW;
  typedef logic [TAG_SIZE-1:0] ptr_t;
  localparam ptr_t FULL = ptr_t'(NUM_TAGS);

  logic [IW-1:0] list [NUM_TAGS];
  ptr_t spec_rd, com_rd, wr, free_cnt;
  ptr_t spec_nxt, com_nxt, wr_nxt;
  ptr_t alloc_n, com_n, free_n;
  ptr_t alloc_ptr  [NUM_ISSUE];
  ptr_t free_ptr   [NUM_COMMIT];
  ptr_t replay_ptr [NUM_COMMIT];
  logic [NUM_COMMIT-1:0] com_phys, free_phys;
  logic do_free;

  // Grant lookup: each requesting slot takes the entry at specRd + its rank among requesters.
  always_comb begin
    alloc_n = '0;
    for (int i = 0; i < NUM_ISSUE; i++) begin
      alloc_ptr[i]     = spec_rd + alloc_n;
      OUT_allocTags[i] = {1'b1, {IW{1'b0}}};
      if (IN_allocReq[i]) begin
        OUT_allocTags[i] = {1'b0, list[alloc_ptr[i][IW-1:0]]};
        alloc_n          = alloc_n + ptr_t'(1);
      end
    end
    OUT_allocOK = (free_cnt >= alloc_n) && !IN_mispred && !IN_mispredFlush;
  end

  always_comb begin
    com_n  = '0;
    free_n = '0;
    for (int j = 0; j < NUM_COMMIT; j++) begin
      com_phys[j]   = IN_commitValid[j] && !IN_commitTags[j][TAG_SIZE-1];
      free_phys[j]  = IN_commitValid[j] && !IN_commitPrevTags[j][TAG_SIZE-1];
      replay_ptr[j] = spec_rd + com_n;
      free_ptr[j]   = wr + free_n;
      if (com_phys[j])  com_n  = com_n + ptr_t'(1);
      if (free_phys[j]) free_n = free_n + ptr_t'(1);
    end
  end

  // Replay (flush without mispred) re-claims tags by advancing only specRd.
  always_comb begin
    spec_nxt = spec_rd;
    com_nxt  = com_rd;
    wr_nxt   = wr;
    do_free  = 1'b0;
    if (IN_mispredFlush) begin
      spec_nxt = IN_mispred ? com_rd : spec_rd + com_n;
    end else begin
      com_nxt = com_rd + com_n;
      wr_nxt  = wr + free_n;
      do_free = 1'b1;
      if (IN_mispred)        spec_nxt = com_nxt;
      else if (IN_allocFire) spec_nxt = spec_rd + alloc_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      spec_rd  <= '0;
      com_rd   <= '0;
      wr       <= FULL;
      free_cnt <= FULL;
      for (int i = 0; i < NUM_TAGS; i++) list[i] <= IW'(i);
    end else begin
      spec_rd  <= spec_nxt;
      com_rd   <= com_nxt;
      wr       <= wr_nxt;
      free_cnt <= wr_nxt - spec_nxt;
      if (do_free)
        for (int j = 0; j < NUM_COMMIT; j++)
          if (free_phys[j]) list[free_ptr[j][IW-1:0]] <= IN_commitPrevTags[j][IW-1:0];
    end
  end

  assign OUT_freeCount = free_cnt;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(IN_allocFire && !OUT_allocOK))
        else $error("tag_free_list: allocFire without allocOK");
      assert (ptr_t'(wr_nxt - com_nxt) <= FULL)
        else $error("tag_free_list: free list overflow");
      if (IN_mispredFlush && !IN_mispred)
        for (int j = 0; j < NUM_COMMIT; j++)
          if (com_phys[j])
            assert (IN_commitTags[j][IW-1:0] == list[replay_ptr[j][IW-1:0]])
              else $error("tag_free_list: replayed tag out of order on port %0d", j);
    end
  end
`endif
endmodule

// File: tb/tb_tag_free_list.sv
// Directed bench for tag_free_list: expectations queued at drive time, popped when outputs are sampled.
module tb_tag_free_list;
  localparam int NI = 4, NC = 4, TS = 7;

  logic clk = 1'b0, rst;
  logic mispred, flush, fire;
  logic [NI-1:0] req;
  logic [NI-1:0][TS-1:0] tags;
  logic ok;
  logic [NC-1:0] cvalid;
  logic [NC-1:0][TS-1:0] ctags, cprev;
  logic [TS-1:0] fcount;

  tag_free_list #(.NUM_ISSUE(NI), .NUM_COMMIT(NC), .TAG_SIZE(TS)) dut (
    .clk(clk), .rst(rst), .IN_mispred(mispred), .IN_mispredFlush(flush),
    .IN_allocReq(req), .IN_allocFire(fire), .OUT_allocTags(tags), .OUT_allocOK(ok),
    .IN_commitValid(cvalid), .IN_commitTags(ctags), .IN_commitPrevTags(cprev),
    .OUT_freeCount(fcount)
  );

  always #5 clk = ~clk;

  typedef struct { string tag; logic [31:0] val; } exp_t;
  exp_t sb [$];
  int total = 0, bad = 0;

  task automatic push(input string t, input logic [31:0] v);
    exp_t e;
    e.tag = t; e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    req = '0; fire = 1'b0; mispred = 1'b0; flush = 1'b0;
    cvalid = '0; ctags = '0; cprev = '0;
  endtask

  task automatic do_reset();
    idle(); rst = 1'b1; step(); step(); rst = 1'b0;
  endtask

  initial begin
    do_reset();
    push("reset_fc", 64); #1 pop_check(32'(fcount));

    // 1111 grant from reset
    req = 4'b1111; fire = 1'b1;
    push("a_ok", 1); push("a_t0", 0); push("a_t1", 1); push("a_t2", 2); push("a_t3", 3);
    #1 pop_check(32'(ok));
    for (int i = 0; i < NI; i++) pop_check(32'(tags[i]));
    push("a_fc", 60); step(); idle(); #1 pop_check(32'(fcount));

    // sparse request 1010
    req = 4'b1010; fire = 1'b1;
    push("b_t0", 'h40); push("b_t1", 4); push("b_t2", 'h40); push("b_t3", 5);
    #1 for (int i = 0; i < NI; i++) pop_check(32'(tags[i]));
    push("b_fc", 58); step(); idle(); #1 pop_check(32'(fcount));

    // drain to empty: tags 6..63
    for (int k = 0; k < 14; k++) begin
      req = 4'b1111; fire = 1'b1; step();
    end
    req = 4'b0011; fire = 1'b1;
    push("drain_last", 63); #1 pop_check(32'(tags[1]));
    step(); idle();
    push("empty_fc", 0); #1 pop_check(32'(fcount));
    req = 4'b0001;
    push("empty_ok", 0); #1 pop_check(32'(ok));

    // free tag 5; not usable or counted in the freeing cycle
    cvalid = 4'b0001; ctags[0] = 7'd6; cprev[0] = 7'd5;
    push("free_same_cycle_ok", 0); #1 pop_check(32'(ok));
    push("free_fc", 1); step(); idle(); #1 pop_check(32'(fcount));
    req = 4'b0001; fire = 1'b1;
    push("refill_ok", 1); push("refill_tag", 5);
    #1 pop_check(32'(ok)); pop_check(32'(tags[0]));
    step(); idle();

    // mispredict rollback and replay
    do_reset();
    req = 4'b1111; fire = 1'b1; step(); step(); idle();
    cvalid = 4'b0011; ctags[0] = 7'd0; ctags[1] = 7'd1; cprev[0] = 7'h40; cprev[1] = 7'h40;
    push("pre_mp_fc", 56); step(); idle(); #1 pop_check(32'(fcount));
    mispred = 1'b1; req = 4'b0001;
    push("mp_ok", 0); #1 pop_check(32'(ok));
    push("mp_fc", 62); step(); idle(); #1 pop_check(32'(fcount));
    flush = 1'b1; cvalid = 4'b0011; ctags[0] = 7'd2; ctags[1] = 7'd3;
    cprev[0] = 7'h40; cprev[1] = 7'h40; req = 4'b0001;
    push("flush_ok", 0); #1 pop_check(32'(ok));
    push("replay_fc", 60); step(); idle(); #1 pop_check(32'(fcount));
    req = 4'b0001; fire = 1'b1;
    push("post_replay_tag", 4); #1 pop_check(32'(tags[0]));
    push("post_replay_fc", 59); step(); idle(); #1 pop_check(32'(fcount));

    // immediate commit/prev tags change nothing
    cvalid = 4'b0001; ctags[0] = 7'h41; cprev[0] = 7'h40;
    push("imm_fc", 59); step(); idle(); #1 pop_check(32'(fcount));
    req = 4'b0001; fire = 1'b1;
    push("imm_tag", 5); #1 pop_check(32'(tags[0]));
    step(); idle();

    // concurrent alloc+free, then reset mid-burst at specRd=10, wr=70
    do_reset();
    req = 4'b1111; fire = 1'b1;
    cvalid = 4'b1111; ctags = {7'd3, 7'd2, 7'd1, 7'd0}; cprev = {7'd3, 7'd2, 7'd1, 7'd0};
    push("mix1_fc", 64); step(); idle(); #1 pop_check(32'(fcount));
    req = 4'b1111; fire = 1'b1;
    cvalid = 4'b0011; ctags[0] = 7'd4; ctags[1] = 7'd5; cprev[0] = 7'd0; cprev[1] = 7'd1;
    push("mix2_fc", 62); step(); idle(); #1 pop_check(32'(fcount));
    req = 4'b0011; fire = 1'b1;
    push("mix3_tag", 8); #1 pop_check(32'(tags[0]));
    push("mix3_fc", 60); step(); idle(); #1 pop_check(32'(fcount));
    rst = 1'b1; req = 4'b1111; fire = 1'b1;
    cvalid = 4'b0001; ctags[0] = 7'd6; cprev[0] = 7'd7;
    step(); rst = 1'b0; idle();
    push("rst_mid_fc", 64); #1 pop_check(32'(fcount));
    req = 4'b0001; fire = 1'b1;
    push("rst_mid_tag", 0); #1 pop_check(32'(tags[0]));
    step(); idle();

    if (sb.size() != 0) begin
      bad++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tag_free_list.md
# tag_free_list

Physical-tag allocator for the register rename stage. It keeps a circular list of free physical tags and hands up to NUM_ISSUE tags per cycle to renaming ops. Prev-tags of committed ops come back into the list, up to NUM_COMMIT per cycle. On a mispredict it rolls the speculative allocation point back to the committed point, and ROB replay during the mispredict flush re-claims tags, mirroring the rename table's spec/committed mapping recovery.

## Interface
- NUM_ISSUE, 4, rename slots per cycle
- NUM_COMMIT, 4, commit ports per cycle
- TAG_SIZE, 7, tag width; MSB set = immediate (non-physical) tag
- NUM_TAGS, 1<<(TAG_SIZE-1), derived; physical tag count
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- IN_mispred  in  1  mispredict recovery this cycle
- IN_mispredFlush  in  1  ROB flush/replay in progress
- IN_allocReq  in  [NUM_ISSUE] x 1  slot i needs a new physical tag
- IN_allocFire  in  1  rename stage consumes this cycle's grant; only legal when OUT_allocOK=1
- OUT_allocTags  out  [NUM_ISSUE] x TAG_SIZE  tag for each requesting slot
- OUT_allocOK  out  1  all requested tags available this cycle
- IN_commitValid  in  [NUM_COMMIT] x 1  commit/replay port valid; upstream never asserts it for rd=x0
- IN_commitTags  in  [NUM_COMMIT] x TAG_SIZE  tag written by the committing op
- IN_commitPrevTags  in  [NUM_COMMIT] x TAG_SIZE  previous committed tag of the same register
- OUT_freeCount  out  TAG_SIZE  registered count of free entries (wr - specRd)

## Operation
- Storage: list[NUM_TAGS] of TAG_SIZE-1 bit indices. Pointers specRd, comRd and wr are TAG_SIZE bits wide, with the MSB as the wrap bit. Index = low TAG_SIZE-1 bits.
- Reset state:
  - list[i]=i
  - specRd=comRd=0
  - wr=NUM_TAGS
  - OUT_freeCount=NUM_TAGS
- Allocation is combinational and all-or-nothing.
  - n = popcount(IN_allocReq).
  - OUT_allocOK = (freeCount >= n) && !IN_mispred && !IN_mispredFlush.
  - Requesting slot i gets {0, list[specRd + popcount(IN_allocReq[i-1:0])]}.
  - Non-requesting slots output {1, 0...0}.
  - When IN_allocFire is set: specRd += n.
- Normal commit (IN_mispredFlush=0), for each valid port j:
  - If IN_commitTags[j] is physical (MSB=0), comRd advances by 1.
  - If IN_commitPrevTags[j] is physical, it is written at list[wr + k], where k = rank among this cycle's physical prev-tags; wr advances by the count.
  - Immediate prev-tags are never freed.
- Replay commit (IN_mispredFlush=1, IN_mispred=0):
  - comRd, wr and list are unchanged.
  - specRd += number of ports with a physical IN_commitTags.
  - Assertion: each replayed physical tag equals list[specRd + rank].
- IN_mispred=1, IN_mispredFlush=0: normal commit processing happens first, then specRd <= the updated comRd. Any IN_allocFire is ignored.
- IN_mispred=1, IN_mispredFlush=1: commit ports are ignored; specRd <= comRd.
- Assertions:
  - IN_allocFire && !OUT_allocOK never occurs.
  - Freeing never makes wr - comRd exceed NUM_TAGS.

## Timing
- Alloc grant: same cycle as the request. Pointer and freeCount update is visible the next cycle.
- Tags freed in cycle t:
  - may be granted from cycle t+1;
  - are not counted in OUT_freeCount during cycle t.
- Alloc and free in the same cycle update specRd and wr independently, so freeCount(t+1) = freeCount(t) - n + freed.
- Mispredict: specRd equals comRd at t+1. OUT_allocOK is 0 during every cycle with mispred or mispredFlush asserted.
- Wrap-around: pointer arithmetic is modulo 2^TAG_SIZE.
  - freeCount=0 means empty.
  - freeCount=NUM_TAGS means full (wrap bits differ, indices equal).
- rst mid-operation overrides every other input and restores the reset state on the next edge.

## Test plan
(TAG_SIZE=7, NUM_TAGS=64)
- Reset, then IN_allocReq=1111 with fire -> tags 0,1,2,3 and OUT_allocOK=1; next cycle OUT_freeCount=60.
- Next cycle IN_allocReq=1010 with fire -> slot1=4, slot3=5, slots 0 and 2 = 0x40; next cycle OUT_freeCount=58.
- Allocate until OUT_freeCount=0, then request 1 -> OUT_allocOK=0. Commit with prevTag=5 -> next cycle OUT_freeCount=1; request 1 -> tag 5 granted.
- From reset, allocate 8 (tags 0-7), then normally commit 2 physical tags -> comRd=2. Then mispred -> specRd=2 and OUT_freeCount=62. Flush replay of tags 2,3 -> OUT_freeCount=60; the next alloc gets tag 4.
- Commit with prevTag=0x40 and commitTag=0x41 -> freeCount, comRd and list are all unchanged.
- Assert rst mid-burst (specRd=10, wr=70) -> next cycle OUT_freeCount=64 and the first alloc returns tag 0.
